// File: rtl/gb_cpu_instr_fetch_pkg.sv
// Shared types and constants for the instruction-boundary fetch stage:
// interrupt sources, vector base and the run/halt state encoding.
package gb_cpu_instr_fetch_pkg;

  typedef enum logic [2:0] {
    INT_VBLANK,
    INT_STAT,
    INT_TIMER,
    INT_SERIAL,
    INT_JOYPAD
  } int_src_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_t;

  localparam logic [7:0] INT_VECTOR_BASE = 8'h40;

  // Each interrupt source owns an 8-byte slot above the vector base.
  function automatic logic [7:0] int_vector(input logic [4:0] idx);
    return INT_VECTOR_BASE + {idx, 3'b000};
  endfunction

endpackage

// File: rtl/gb_cpu_instr_fetch_int_priority.sv
// Fixed-priority interrupt resolver: bit 0 of pending is the highest priority.
module gb_cpu_int_priority #(
  parameter int unsigned NUM_INT = 5,
  parameter int unsigned IDX_W   = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
  input  logic [NUM_INT-1:0] pending,
  output logic               any_pend,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_INT-1:0] onehot
);

  always_comb begin
    any_pend = |pending;
    idx      = '0;
    onehot   = '0;
    // Walk from the lowest priority down so the last hit is the winner.
    for (int unsigned i = NUM_INT; i > 0; i--) begin
      if (pending[i-1]) begin
        idx    = IDX_W'(i - 1);
        onehot = NUM_INT'(1) << (i - 1);
      end
    end
  end

endmodule

// File: rtl/gb_cpu_instr_fetch.sv
// Instruction-boundary stage: latches the next opcode, tracks CB prefix,
// IME and HALT, and injects the interrupt-dispatch pseudo-instruction.
module gb_cpu_instr_fetch
  import gb_cpu_instr_fetch_pkg::*;
#(
  parameter int unsigned NUM_INT      = 5,
  parameter logic [7:0]  RESET_OPCODE = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               last_m_cycle_i,
  input  logic [7:0]         data_bus_i,
  input  logic               cb_prefix_i,
  input  logic               enable_interrupts,
  input  logic               enable_interrupts_imm,
  input  logic               disable_interrupts,
  input  logic               halt_req,
  input  logic [NUM_INT-1:0] int_flag,
  input  logic [NUM_INT-1:0] int_enable,
  output logic [7:0]         opcode_o,
  output logic               cb_prefix_o,
  output logic               int_dispatch_o,
  output logic [7:0]         int_vector_o,
  output logic [NUM_INT-1:0] int_ack_o,
  output logic               ime_o,
  output logic               halted_o
);

  localparam int unsigned IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  fetch_state_t       state;
  logic               any_pend;
  logic [IDX_W-1:0]   idx;
  logic [NUM_INT-1:0] onehot;
  logic               boundary;
  logic               take_int;
  logic               dispatch;
  logic               enter_halt;
  logic               ime_next;

  gb_cpu_int_priority #(
    .NUM_INT (NUM_INT),
    .IDX_W   (IDX_W)
  ) u_int_priority (
    .pending  (int_flag & int_enable),
    .any_pend (any_pend),
    .idx      (idx),
    .onehot   (onehot)
  );

  assign halted_o = (state == FETCH_HALT);

  // take_int only clears IME when it actually becomes a dispatch, so a
  // pending interrupt seen mid-instruction is not lost.
  always_comb begin
    boundary   = last_m_cycle_i && (state == FETCH_RUN);
    take_int   = any_pend && ime_o && !disable_interrupts && !cb_prefix_i;
    dispatch   = take_int && (boundary || (state == FETCH_HALT));
    enter_halt = boundary && halt_req && !any_pend;
    ime_next   = ime_o;
    if (dispatch)                             ime_next = 1'b0;
    else if (disable_interrupts)              ime_next = 1'b0;
    else if (enable_interrupts_imm)           ime_next = 1'b1;
    else if (enable_interrupts && boundary)   ime_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH_RUN;
      opcode_o       <= RESET_OPCODE;
      cb_prefix_o    <= 1'b0;
      int_dispatch_o <= 1'b0;
      int_vector_o   <= '0;
      int_ack_o      <= '0;
      ime_o          <= 1'b0;
    end else begin
      int_ack_o <= '0;
      ime_o     <= ime_next;
      if (dispatch) begin
        state          <= FETCH_RUN;
        int_dispatch_o <= 1'b1;
        int_vector_o   <= int_vector(5'(idx));
        int_ack_o      <= onehot;
        cb_prefix_o    <= 1'b0;
      end else if (enter_halt) begin
        state <= FETCH_HALT;
      end else if (boundary) begin
        opcode_o       <= data_bus_i;
        cb_prefix_o    <= cb_prefix_i;
        int_dispatch_o <= 1'b0;
      end else if ((state == FETCH_HALT) && any_pend) begin
        state          <= FETCH_RUN;
        opcode_o       <= data_bus_i;
        cb_prefix_o    <= 1'b0;
        int_dispatch_o <= 1'b0;
      end
    end
  end

endmodule
